// File: rtl/keypad_pkg.sv
// Shared types and elaboration helpers for the matrix keypad scanner.
// Latency: none (types, constants and constant functions only).
// Backpressure: none.
//
// Contents: scanner FSM state encoding, a clog2 constant function and a
// parameter-legality predicate used by the top level at elaboration.
package keypad_pkg;

  // Scanner FSM states.
  typedef enum logic [1:0] {
    SCAN   = 2'd0,
    DEB    = 2'd1,
    HELD   = 2'd2,
    REL_DB = 2'd3
  } state_t;

  // Ceiling log2, with a minimum of 1 so every derived vector has a bit.
  function automatic int kp_clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Legal geometry and timing: at least a 2x2 matrix, a dwell of at least
  // two clocks and a debounce depth of at least one sample.
  function automatic bit params_legal(input int rows, input int cols,
                                      input int scan_div, input int debounce);
    return (rows >= 2) && (cols >= 2) && (scan_div >= 2) && (debounce >= 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a bus of independent asynchronous level inputs.
// Latency: 2 i_clk cycles from i_d to o_q.
// Backpressure: none; free-running.
//
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset; both stages reset to all 1s
//   i_d      asynchronous input bus (WIDTH bits)
//   o_q      synchronised output bus (WIDTH bits)
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Reset value is all 1s: an idle active-low keypad reads as no key.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// ROWS x COLS matrix keypad scanner with debounced press/release strobes.
// Latency: key_valid one clk after the DEBOUNCE-th matching dwell sample.
// Backpressure: none; strobes are single-cycle and must be consumed on sight.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   row          keypad row sense, active-low, asynchronous to clk
//   col_drive    one-hot-low column drive
//   key_code     sticky code of last accepted key (col_idx*ROWS + row_idx)
//   key_valid    one-cycle strobe on accepted press
//   key_held     high while an accepted key is pressed
//   key_release  one-cycle strobe on accepted release
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 8,
  localparam int CODE_W  = kp_clog2(ROWS * COLS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ROWS-1:0]   row,
  output logic [COLS-1:0]   col_drive,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_held,
  output logic              key_release
);

  localparam int RW  = kp_clog2(ROWS);
  localparam int CIW = kp_clog2(COLS);
  localparam int DW  = kp_clog2(SCAN_DIV);
  localparam int CW  = kp_clog2(DEBOUNCE + 1);

  localparam logic [DW-1:0]  DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CIW-1:0] COL_LAST = CIW'(COLS - 1);
  // r_cnt holds matching samples already seen; the current sample is the
  // accepting one when r_cnt equals DEBOUNCE-1.
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE - 1);

  if (!params_legal(ROWS, COLS, SCAN_DIV, DEBOUNCE)) begin : g_bad_params
    $error("keypad_scanner: illegal ROWS/COLS/SCAN_DIV/DEBOUNCE");
  end

  state_t            r_state, w_state_nxt;
  logic [DW-1:0]     r_div;
  logic [CIW-1:0]    r_col_idx, w_col_nxt, w_col_adv;
  logic [RW-1:0]     r_row_idx, w_row_nxt, w_low_row;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic [CODE_W-1:0] r_code, w_code_nxt, w_code_scan, w_code_deb;
  logic              r_valid, w_valid_nxt;
  logic              r_rel, w_rel_nxt;
  logic [ROWS-1:0]   w_rs;
  logic              w_sample;
  logic              w_any_low;
  logic              w_row_low;

  sync_2ff #(.WIDTH(ROWS)) u_row_sync (
    .i_clk  (clk),
    .i_rst_n(reset),
    .i_d    (row),
    .o_q    (w_rs)
  );

  // Free-running dwell counter; the last count of each dwell is the sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div <= '0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DW'(1);
    end
  end

  assign w_sample  = (r_div == DIV_LAST);
  assign w_any_low = ~&w_rs;
  assign w_row_low = ~w_rs[r_row_idx];
  assign w_col_adv = (r_col_idx == COL_LAST) ? '0 : r_col_idx + CIW'(1);

  // Lowest-index low row wins when several rows are pressed at detection.
  always_comb begin
    w_low_row = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (!w_rs[i]) begin
        w_low_row = RW'(i);
      end
    end
  end

  assign w_code_scan = CODE_W'(int'(r_col_idx) * ROWS + int'(w_low_row));
  assign w_code_deb  = CODE_W'(int'(r_col_idx) * ROWS + int'(r_row_idx));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= SCAN;
      r_col_idx <= '0;
      r_row_idx <= '0;
      r_cnt     <= '0;
      r_code    <= '0;
      r_valid   <= 1'b0;
      r_rel     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_col_idx <= w_col_nxt;
      r_row_idx <= w_row_nxt;
      r_cnt     <= w_cnt_nxt;
      r_code    <= w_code_nxt;
      r_valid   <= w_valid_nxt;
      r_rel     <= w_rel_nxt;
    end
  end

  // All decisions happen only on the sample cycle; the column stays frozen
  // from detection until the key is either rejected or released.
  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col_idx;
    w_row_nxt   = r_row_idx;
    w_cnt_nxt   = r_cnt;
    w_code_nxt  = r_code;
    w_valid_nxt = 1'b0;
    w_rel_nxt   = 1'b0;
    if (w_sample) begin
      unique case (r_state)
        SCAN: begin
          if (w_any_low) begin
            w_row_nxt = w_low_row;
            if (DEBOUNCE == 1) begin
              w_state_nxt = HELD;
              w_code_nxt  = w_code_scan;
              w_valid_nxt = 1'b1;
              w_cnt_nxt   = '0;
            end else begin
              w_state_nxt = DEB;
              w_cnt_nxt   = CW'(1);
            end
          end else begin
            w_col_nxt = w_col_adv;
          end
        end
        DEB: begin
          if (w_row_low) begin
            if (r_cnt == CNT_LAST) begin
              w_state_nxt = HELD;
              w_code_nxt  = w_code_deb;
              w_valid_nxt = 1'b1;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt + CW'(1);
            end
          end else begin
            w_state_nxt = SCAN;
            w_cnt_nxt   = '0;
            w_col_nxt   = w_col_adv;
          end
        end
        HELD: begin
          // Other rows in the frozen column are ignored: no rollover.
          if (!w_row_low) begin
            if (DEBOUNCE == 1) begin
              w_state_nxt = SCAN;
              w_rel_nxt   = 1'b1;
              w_cnt_nxt   = '0;
              w_col_nxt   = w_col_adv;
            end else begin
              w_state_nxt = REL_DB;
              w_cnt_nxt   = CW'(1);
            end
          end
        end
        REL_DB: begin
          if (!w_row_low) begin
            if (r_cnt == CNT_LAST) begin
              w_state_nxt = SCAN;
              w_rel_nxt   = 1'b1;
              w_cnt_nxt   = '0;
              w_col_nxt   = w_col_adv;
            end else begin
              w_cnt_nxt = r_cnt + CW'(1);
            end
          end else begin
            // Release bounce: key still down, back to HELD silently.
            w_state_nxt = HELD;
            w_cnt_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = SCAN;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign col_drive   = ~(COLS'(1) << r_col_idx);
  assign key_code    = r_code;
  assign key_valid   = r_valid;
  assign key_release = r_rel;
  assign key_held    = (r_state == HELD) || (r_state == REL_DB);

endmodule
